ex_mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage: EX/MEM pipeline register, 64-bit byte-addressable data memory, and load/store alignment logic for RV64I.
- Captures execute-stage results (ALU result, store data, control) and performs the memory access in the M stage.
- Produces ALUResult_M for execute-stage forwarding, plus ReadData_M and control for writeback.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/data_mem.sv | 27 ++
 rtl/ex_mem_stage.sv | 112 +++++++++++
 tb/tb_ex_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64I load/store encodings and lane-mask helpers
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'b00,
        MEM_HALF   = 2'b01,
        MEM_WORD   = 2'b10,
        MEM_DOUBLE = 2'b11
    } mem_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // byte lanes touched by an aligned access of the given size
    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            MEM_BYTE: return 8'h01;
            MEM_HALF: return 8'h03;
            MEM_WORD: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

    // offset bits that survive alignment to the given size
    function automatic logic [2:0] align_mask(input mem_size_t size);
        case (size)
            MEM_BYTE: return 3'b111;
            MEM_HALF: return 3'b110;
            MEM_WORD: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 64-bit word data memory, combinational read, byte-enabled posedge write
module data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_BITS    = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] idx,
    input  logic [7:0]          be,
    input  logic [63:0]         wdata,
    output logic [63:0]         rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    // byte-lane write; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM register, data memory access and load/store alignment (option: MEM_MISALIGN_TRAP_EN)
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_BITS    = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ALUResult_E,
    input  logic [63:0] WriteData_E,
    input  logic [63:0] PCPlus4_E,
    input  logic [4:0]  Rd_E,
    input  logic        RegWrite_E,
    input  logic        MemWrite_E,
    input  logic [1:0]  ResultSrc_E,
    input  logic [2:0]  Funct3_E,
    input  logic        Stall_M,
    input  logic        Flush_M,
    output logic [63:0] ALUResult_M,
    output logic [63:0] ReadData_M,
    output logic [63:0] PCPlus4_M,
    output logic [4:0]  Rd_M,
    output logic        RegWrite_M,
    output logic [1:0]  ResultSrc_M,
    output logic        Misaligned_M
);

    logic [63:0] alu_m, wdata_m, pc4_m;
    logic [4:0]  rd_m;
    logic        regwrite_m, memwrite_m, valid_m;
    logic [1:0]  resultsrc_m;
    logic [2:0]  funct3_m;

    // M register: reset and flush both leave a bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst || Flush_M) begin
            alu_m       <= '0;
            wdata_m     <= '0;
            pc4_m       <= '0;
            rd_m        <= '0;
            regwrite_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            resultsrc_m <= RES_ALU;
            funct3_m    <= 3'b000;
            valid_m     <= 1'b0;
        end else if (!Stall_M) begin
            alu_m       <= ALUResult_E;
            wdata_m     <= WriteData_E;
            pc4_m       <= PCPlus4_E;
            rd_m        <= Rd_E;
            regwrite_m  <= RegWrite_E;
            memwrite_m  <= MemWrite_E;
            resultsrc_m <= ResultSrc_E;
            funct3_m    <= Funct3_E;
            valid_m     <= 1'b1;
        end
    end

    mem_size_t   size;
    logic [2:0]  raw_off, off;
    logic [5:0]  shamt;
    logic        mis_cond, flag, load_flag;
    logic [7:0]  be;
    logic [63:0] lane_data, word_rd, shifted, ext;

    // lane selection, misalignment handling and load extension
    always_comb begin
        size     = mem_size_t'(funct3_m[1:0]);
        raw_off  = alu_m[2:0];
        mis_cond = (raw_off & ~align_mask(size)) != 3'b000;
`ifdef MEM_MISALIGN_TRAP_EN
        off      = raw_off;
        flag     = (memwrite_m || resultsrc_m == RES_MEM) && mis_cond;
`else
        off      = raw_off & align_mask(size);
        flag     = 1'b0;
`endif
        load_flag = flag && (resultsrc_m == RES_MEM);
        shamt     = {off, 3'b000};
        be        = size_mask(size) << off;
        lane_data = wdata_m << shamt;
        shifted   = word_rd >> shamt;
        case (size)
            MEM_BYTE: ext = funct3_m[2] ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            MEM_HALF: ext = funct3_m[2] ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            MEM_WORD: ext = funct3_m[2] ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default:  ext = shifted;
        endcase
    end

    data_mem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_BITS   (IDX_BITS)
    ) u_data_mem (
        .clk  (clk),
        .we   (memwrite_m && !flag),
        .idx  (alu_m[IDX_BITS+2:3]),
        .be   (be),
        .wdata(lane_data),
        .rdata(word_rd)
    );

    assign ALUResult_M  = alu_m;
    assign ReadData_M   = (valid_m && !load_flag) ? ext : 64'd0;
    assign PCPlus4_M    = pc4_m;
    assign Rd_M         = rd_m;
    assign RegWrite_M   = regwrite_m && !load_flag;
    assign ResultSrc_M  = resultsrc_m;
    assign Misaligned_M = flag;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized bench for ex_mem_stage against a byte-array memory model
module tb_ex_mem_stage;
    localparam int MEM_BYTES = 1024 * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ALUResult_E = '0, WriteData_E = '0, PCPlus4_E = '0;
    logic [4:0]  Rd_E = '0;
    logic        RegWrite_E = 1'b0, MemWrite_E = 1'b0;
    logic [1:0]  ResultSrc_E = '0;
    logic [2:0]  Funct3_E = '0;
    logic        Stall_M = 1'b0, Flush_M = 1'b0;
    logic [63:0] ALUResult_M, ReadData_M, PCPlus4_M;
    logic [4:0]  Rd_M;
    logic        RegWrite_M, Misaligned_M;
    logic [1:0]  ResultSrc_M;

    ex_mem_stage #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .ALUResult_E(ALUResult_E), .WriteData_E(WriteData_E), .PCPlus4_E(PCPlus4_E),
        .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
        .ResultSrc_E(ResultSrc_E), .Funct3_E(Funct3_E),
        .Stall_M(Stall_M), .Flush_M(Flush_M),
        .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M),
        .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
        .Misaligned_M(Misaligned_M)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference state: byte memory plus the instruction believed to sit in M
    logic [7:0]  mem_model [MEM_BYTES];
    logic        m_valid = 1'b0, m_rw = 1'b0, m_mw = 1'b0;
    logic [63:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_rs = '0;
    logic [2:0]  m_f3 = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int acc_bytes();
        return 1 << m_f3[1:0];
    endfunction

    function automatic int byte_addr();
        return int'(m_alu % 64'(MEM_BYTES));
    endfunction

    function automatic logic m_flag();
`ifdef MEM_MISALIGN_TRAP_EN
        return m_valid && (m_mw || m_rs == 2'b01) && (byte_addr() % acc_bytes() != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_addr();
`ifdef MEM_MISALIGN_TRAP_EN
        return byte_addr();
`else
        return byte_addr() - (byte_addr() % acc_bytes());
`endif
    endfunction

    function automatic logic [63:0] exp_read();
        logic [63:0] v = '0;
        int n = acc_bytes();
        if (!m_valid || m_flag()) return 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_model[(eff_addr() + i) % MEM_BYTES];
        if (!m_f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic compare_outputs();
        check_eq("alu_m",     ALUResult_M, m_alu);
        check_eq("read_data", ReadData_M, exp_read());
        check_eq("pc4_m",     PCPlus4_M, m_pc4);
        check_eq("rd_m",      64'(Rd_M), 64'(m_rd));
        check_eq("regwrite",  64'(RegWrite_M), 64'(m_rw && !(m_flag() && m_rs == 2'b01)));
        check_eq("resultsrc", 64'(ResultSrc_M), 64'(m_rs));
        check_eq("misalign",  64'(Misaligned_M), 64'(m_flag()));
    endtask

    task automatic commit_store();
        if (m_valid && m_mw && !m_flag())
            for (int i = 0; i < acc_bytes(); i++)
                mem_model[(eff_addr() + i) % MEM_BYTES] = m_wd[8*i +: 8];
    endtask

    task automatic clear_model_m();
        m_valid = 0; m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
        m_rw = 0; m_mw = 0; m_rs = '0; m_f3 = '0;
    endtask

    task automatic step(input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pc4,
                        input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic stall, input logic flush);
        ALUResult_E = alu; WriteData_E = wd; PCPlus4_E = pc4; Rd_E = rd;
        RegWrite_E = rw; MemWrite_E = mw; ResultSrc_E = rs; Funct3_E = f3;
        Stall_M = stall; Flush_M = flush;
        @(posedge clk); #1;
        if (flush) clear_model_m();
        else if (!stall) begin
            m_valid = 1; m_alu = alu; m_wd = wd; m_pc4 = pc4; m_rd = rd;
            m_rw = rw; m_mw = mw; m_rs = rs; m_f3 = f3;
        end
        compare_outputs();
        commit_store();
        Stall_M = 0; Flush_M = 0;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] f3);
        step(a, d, 64'h1000, 5'd0, 1'b0, 1'b1, 2'b00, f3, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [63:0] a, input logic [2:0] f3);
        step(a, 64'h0, 64'h2000, 5'd7, 1'b1, 1'b0, 2'b01, f3, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ALUResult_E = 64'h48; WriteData_E = 64'hFFFF_FFFF_FFFF_FFFF; PCPlus4_E = 64'h44;
        Rd_E = 5'd31; RegWrite_E = 1; MemWrite_E = 1; ResultSrc_E = 2'b10; Funct3_E = 3'b011;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        clear_model_m();
        compare_outputs();
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'h00;
        do_reset();
        check_eq("reset_regwrite", 64'(RegWrite_M), 64'd0);

        // give the DUT memory a known all-zero image
        for (int w = 0; w < 1024; w++) store(64'(w * 8), 64'd0, 3'b011);

        store(64'h40, 64'h1122334455667788, 3'b011);
        load(64'h40, 3'b011);
        check_eq("sd_ld_40", ReadData_M, 64'h1122334455667788);

        do_reset();
        load(64'h40, 3'b011);
        check_eq("mem_kept_over_rst", ReadData_M, 64'h1122334455667788);

        store(64'h43, 64'h80, 3'b000);
        load(64'h43, 3'b000);
        check_eq("lb_43", ReadData_M, 64'hFFFFFFFFFFFFFF80);
        load(64'h43, 3'b100);
        check_eq("lbu_43", ReadData_M, 64'h80);
        load(64'h40, 3'b011);
        check_eq("ld_40_merge", ReadData_M, 64'h1122334480667788);

        store(64'h10, 64'hDEADBEEFCAFEF00D, 3'b011);
        step(64'h10, 64'h12345678, 64'h0, 5'd3, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 1'b1);
        check_eq("flush_regwrite", 64'(RegWrite_M), 64'd0);
        load(64'h10, 3'b010);
        check_eq("lw_after_flush", ReadData_M, 64'hFFFFFFFFCAFEF00D);
        for (int s = 0; s < 3; s++) begin
            step(64'h999, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0);
            check_eq("stall_hold", ALUResult_M, 64'h10);
        end

        store(64'h2000, 64'hA5, 3'b011);
        load(64'h0, 3'b011);
        check_eq("wrap_ld0", ReadData_M, 64'hA5);

        load(64'h41, 3'b001);
`ifdef MEM_MISALIGN_TRAP_EN
        check_eq("lh41_flag", 64'(Misaligned_M), 64'd1);
        check_eq("lh41_rw", 64'(RegWrite_M), 64'd0);
        check_eq("lh41_data", ReadData_M, 64'd0);
`else
        check_eq("lh41_flag", 64'(Misaligned_M), 64'd0);
        check_eq("lh41_data", ReadData_M, 64'h7788);
`endif

        for (int n = 0; n < 500; n++) begin
            logic [63:0] a, d, p;
            int op;
            op = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            d = {$urandom, $urandom};
            p = {$urandom, $urandom};
            case (op)
                0: step(a, d, p, 5'($urandom), 1'b0, 1'b1, 2'b00, 3'($urandom_range(0, 3)),
                        $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
                1: step(a, d, p, 5'($urandom), 1'b1, 1'b0, 2'b01, 3'($urandom_range(0, 7)),
                        $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
                default: step(a, d, p, 5'($urandom), 1'($urandom), 1'b0,
                              ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, 3'($urandom),
                              $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
